// File: rtl/alu_seq.sv
// Clocked, parametrised ALU: 16 opcodes with a valid/ready input handshake.
// Single-cycle ops are pipelined; MUL and DIV iterate. Define ALU_SAT_EN to clamp ADD/SUB/INC/DEC.
module alu_seq #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   a_in,
   input  logic [W-1:0]   b_in,
   input  logic [3:0]     command_in,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           oe,
   output logic [2*W-1:0] d_out,
   output logic           out_valid,
   output logic           div_err
);

   localparam int CW = $clog2(W + 1);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_INC  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_DEC  = 4'h3;
   localparam logic [3:0] OP_MUL  = 4'h4;
   localparam logic [3:0] OP_DIV  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_INV  = 4'hA;
   localparam logic [3:0] OP_NAND = 4'hB;
   localparam logic [3:0] OP_NOR  = 4'hC;
   localparam logic [3:0] OP_XOR  = 4'hD;
   localparam logic [3:0] OP_XNOR = 4'hE;
   localparam logic [3:0] OP_BUF  = 4'hF;

   typedef enum logic {IDLE, CALC} state_t;

   state_t           state, state_next;
   logic             accept, iter_cmd;
   logic [3:0]       op_q;
   logic [W-1:0]     a_q, b_q, mag_a, mag_b, mag_b_q;
   logic             pend_q, fin_q;
   logic [CW-1:0]    cnt;
   logic [2*W-1:0]   acc, mcand;
   logic [W-1:0]     mplier, rem_q, quo_q;
   logic [W:0]       div_shift, div_diff;
   logic [2*W-1:0]   result_q, ea, eb, raw_arith, arith_res, single_res, iter_res;
   logic [W-1:0]     quo_fix, rem_fix;

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign iter_cmd = (command_in == OP_MUL) || (command_in == OP_DIV);
   assign mag_a    = a_in[W-1] ? (~a_in + W'(1)) : a_in;
   assign mag_b    = b_in[W-1] ? (~b_in + W'(1)) : b_in;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (accept && iter_cmd) state_next = CALC;
         CALC: if (cnt == CW'(1))      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One restoring-division step: bring in the next dividend bit, subtract if it fits.
   assign div_shift = {rem_q, quo_q[W-1]};
   assign div_diff  = div_shift - {1'b0, mag_b_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         mag_b_q   <= '0;
         pend_q    <= 1'b0;
         fin_q     <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         result_q  <= '0;
         out_valid <= 1'b0;
         div_err   <= 1'b0;
      end else begin
         pend_q    <= accept && !iter_cmd;
         fin_q     <= 1'b0;
         out_valid <= 1'b0;
         if (accept) begin
            op_q    <= command_in;
            a_q     <= a_in;
            b_q     <= b_in;
            mag_b_q <= mag_b;
            if (iter_cmd) begin
               cnt    <= CW'(W);
               acc    <= '0;
               mcand  <= {{W{1'b0}}, mag_a};
               mplier <= mag_b;
               rem_q  <= '0;
               quo_q  <= mag_a;
            end
         end
         if (state == CALC) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) fin_q <= 1'b1;
            if (op_q == OP_MUL) begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end else if (!div_diff[W]) begin
               rem_q <= div_diff[W-1:0];
               quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
               rem_q <= div_shift[W-1:0];
               quo_q <= {quo_q[W-2:0], 1'b0};
            end
         end
         if (pend_q) begin
            result_q  <= single_res;
            out_valid <= 1'b1;
         end else if (fin_q) begin
            result_q  <= iter_res;
            out_valid <= 1'b1;
            if (op_q == OP_DIV) div_err <= (b_q == '0);
         end
      end
   end

   assign ea = {{W{a_q[W-1]}}, a_q};
   assign eb = {{W{b_q[W-1]}}, b_q};

   always_comb begin
      raw_arith = ea + eb;
      unique case (op_q)
         OP_INC:  raw_arith = ea + (2*W)'(1);
         OP_SUB:  raw_arith = ea - eb;
         OP_DEC:  raw_arith = ea - (2*W)'(1);
         default: raw_arith = ea + eb;
      endcase
   end

`ifdef ALU_SAT_EN
   localparam logic [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
   assign arith_res = ($signed(raw_arith) > $signed(SAT_MAX)) ? SAT_MAX :
                      ($signed(raw_arith) < $signed(SAT_MIN)) ? SAT_MIN : raw_arith;
`else
   assign arith_res = raw_arith;
`endif

   always_comb begin
      single_res = '0;
      unique case (op_q)
         OP_ADD, OP_INC, OP_SUB, OP_DEC: single_res = arith_res;
         OP_SHL:  single_res = ea << 1;
         OP_SHR:  single_res = {{(W+1){a_q[W-1]}}, a_q[W-1:1]};
         OP_AND:  single_res = {{W{1'b0}}, a_q & b_q};
         OP_OR:   single_res = {{W{1'b0}}, a_q | b_q};
         OP_INV:  single_res = {{W{1'b0}}, ~a_q};
         OP_NAND: single_res = {{W{1'b0}}, ~(a_q & b_q)};
         OP_NOR:  single_res = {{W{1'b0}}, ~(a_q | b_q)};
         OP_XOR:  single_res = {{W{1'b0}}, a_q ^ b_q};
         OP_XNOR: single_res = {{W{1'b0}}, ~(a_q ^ b_q)};
         OP_BUF:  single_res = ea;
         default: single_res = '0;
      endcase
   end

   // The datapath works on magnitudes; signs are restored here from the latched operands.
   always_comb begin
      quo_fix  = (a_q[W-1] ^ b_q[W-1]) ? (~quo_q + W'(1)) : quo_q;
      rem_fix  = a_q[W-1] ? (~rem_q + W'(1)) : rem_q;
      iter_res = {rem_fix, quo_fix};
      if (op_q == OP_MUL)
         iter_res = (a_q[W-1] ^ b_q[W-1]) ? (~acc + (2*W)'(1)) : acc;
      else if (b_q == '0)
         iter_res = {a_q, {W{1'b1}}};
   end

   assign d_out = oe ? result_q : 'z;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (W=8); expectations follow ALU_SAT_EN when defined.
module tb_alu_seq;

   localparam int W = 8;
   localparam logic [15:0] BUS_PAT = 16'hA5C3;

   logic        clk = 1'b0;
   logic        rst, in_valid, oe, in_ready, out_valid, div_err, tb_drive;
   logic [7:0]  a_in, b_in;
   logic [3:0]  command_in;
   wire  [15:0] d_bus;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // A second driver on the bus proves the DUT really releases it when oe is low.
   assign d_bus = tb_drive ? BUS_PAT : 'z;

   alu_seq #(.W(W)) dut (
      .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .command_in(command_in),
      .in_valid(in_valid), .in_ready(in_ready), .oe(oe), .d_out(d_bus),
      .out_valid(out_valid), .div_err(div_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
      command_in = cmd;
      a_in       = a;
      b_in       = b;
      in_valid   = 1'b1;
   endtask

   // Issue one op from idle and wait (bounded) for its out_valid pulse.
   task automatic runOp(input string tag, input logic [3:0] cmd, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input int exp_lat);
      int lat;
      logic seen;
      checkOutput({tag, "_rdy"}, in_ready, 1);
      applyStimulus(cmd, a, b);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat  = 0;
      seen = out_valid;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         seen = out_valid;
      end
      checkOutput({tag, "_lat"}, seen ? lat : -1, exp_lat);
      checkOutput(tag, d_bus, exp);
   endtask

   logic [15:0] sweep [16] = '{16'h0069, 16'h005B, 16'h004B, 16'h0059, 16'h0546, 16'h0006,
                               16'h00B4, 16'h002D, 16'h000A, 16'h005F, 16'h00A5, 16'h00F5,
                               16'h00A0, 16'h0055, 16'h00AA, 16'h005A};

   initial begin
      int   lowcnt;
      logic ov_seen;
      rst = 1'b1; in_valid = 1'b0; oe = 1'b1; tb_drive = 1'b0;
      a_in = '0; b_in = '0; command_in = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", in_ready, 0);
      checkOutput("rst_ov", out_valid, 0);
      checkOutput("rst_dout", d_bus, 0);
      checkOutput("rst_derr", div_err, 0);
      rst = 1'b0;
      #1 checkOutput("rst_ready_after", in_ready, 1);
      @(negedge clk);

      // Back-to-back single-cycle ops
      applyStimulus(4'h0, 8'd25, 8'd17);
      @(negedge clk);
      applyStimulus(4'h2, 8'd20, 8'd10);
      checkOutput("t1_ov_early", out_valid, 0);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("t1_add_ov", out_valid, 1);
      checkOutput("t1_add", d_bus, 16'h002A);
      @(negedge clk);
      checkOutput("t1_sub_ov", out_valid, 1);
      checkOutput("t1_sub", d_bus, 16'h000A);
      @(negedge clk);
      checkOutput("t1_ov_drop", out_valid, 0);

      // MUL with a competing request held during CALC
      applyStimulus(4'h4, 8'hFD, 8'd5);
      @(posedge clk);
      lowcnt  = 0;
      ov_seen = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) applyStimulus(4'h0, 8'd1, 8'd1);
         if (!in_ready) lowcnt++;
         if (out_valid) ov_seen = 1'b1;
      end
      in_valid = 1'b0;
      checkOutput("t2_busy_cycles", lowcnt, 8);
      checkOutput("t2_ov_early", ov_seen, 0);
      @(negedge clk);
      checkOutput("t2_ready_back", in_ready, 1);
      checkOutput("t2_ov_pre", out_valid, 0);
      @(negedge clk);
      checkOutput("t2_ov", out_valid, 1);
      checkOutput("t2_mul", d_bus, 16'hFFF1);
      @(negedge clk);
      checkOutput("t2_ov_drop", out_valid, 0);
      checkOutput("t2_hold", d_bus, 16'hFFF1);

      // Division, divide by zero and div_err persistence
      runOp("t3_div_m7_2", 4'h5, 8'hF9, 8'd2, 16'hFFFD, 9);
      checkOutput("t3_derr0", div_err, 0);
      runOp("t3_div_9_0", 4'h5, 8'd9, 8'd0, 16'h09FF, 9);
      checkOutput("t3_derr1", div_err, 1);
      runOp("t3_add", 4'h0, 8'd1, 8'd2, 16'h0003, 1);
      checkOutput("t3_derr_kept", div_err, 1);
      runOp("t3_div_7_m2", 4'h5, 8'd7, 8'hFE, 16'h01FD, 9);
      checkOutput("t3_derr_clr", div_err, 0);
      runOp("t3_div_m128_3", 4'h5, 8'h80, 8'd3, 16'hFED6, 9);
      runOp("t3_mul_m128sq", 4'h4, 8'h80, 8'h80, 16'h4000, 9);

      // Opcode sweep with oe dropped for the middle four opcodes
      for (int i = 0; i < 16; i++) begin
         if (i >= 8 && i <= 11) begin
            oe = 1'b0;
            tb_drive = 1'b1;
         end
         runOp($sformatf("t4_op%0h", i), 4'(i), 8'h5A, 8'h0F,
               (i >= 8 && i <= 11) ? BUS_PAT : sweep[i], (i == 4 || i == 5) ? 9 : 1);
         if (i == 11) begin
            oe = 1'b1;
            tb_drive = 1'b0;
            #1 checkOutput("t4_hold_after_oe", d_bus, 16'h00F5);
         end
      end

      // Reset in the middle of a DIV
      @(negedge clk);
      applyStimulus(4'h5, 8'd100, 8'd3);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1 checkOutput("t5_ready_in_rst", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 checkOutput("t5_ready_after", in_ready, 1);
      ov_seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1'b1;
      end
      checkOutput("t5_no_ov", ov_seen, 0);
      checkOutput("t5_dout_clr", d_bus, 0);
      runOp("t5_add", 4'h0, 8'd3, 8'd4, 16'h0007, 1);

      // Arithmetic at the edges of the signed range
`ifdef ALU_SAT_EN
      runOp("t6_add", 4'h0, 8'd100, 8'd100, 16'h007F, 1);
      runOp("t6_sub", 4'h2, 8'h80, 8'd1, 16'hFF80, 1);
      runOp("t6_dec", 4'h3, 8'h80, 8'd0, 16'hFF80, 1);
      runOp("t6_inc", 4'h1, 8'h7F, 8'd0, 16'h007F, 1);
`else
      runOp("t6_add", 4'h0, 8'd100, 8'd100, 16'h00C8, 1);
      runOp("t6_sub", 4'h2, 8'h80, 8'd1, 16'hFF7F, 1);
      runOp("t6_dec", 4'h3, 8'h80, 8'd0, 16'hFF7F, 1);
      runOp("t6_inc", 4'h1, 8'h7F, 8'd0, 16'h0080, 1);
`endif
      runOp("t6_mul_m128_1", 4'h4, 8'h80, 8'd1, 16'hFF80, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
